// File: rtl/ball_table_ctrl_pkg.sv
// Shared types and register-map constants for the double-buffered ball descriptor table.
// Types and constants only: no latency and no backpressure.
package ball_table_ctrl_pkg;

    localparam int NUM_BALLS_DEFAULT = 16;

    // CTRL write bits
    localparam int CTRL_COMMIT_BIT  = 0;
    localparam int CTRL_IRQ_CLR_BIT = 1;

    // CTRL read bits
    localparam int STAT_PENDING_BIT = 0;
    localparam int STAT_COPYING_BIT = 1;
    localparam int STAT_IRQ_BIT     = 2;
    localparam int STAT_FRAME_LSB   = 16;

    typedef struct packed {
        logic       visible;
        logic [5:0] radius;
        logic [9:0] y;
        logic [9:0] x;
    } ball_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PENDING,
        ST_SWAP,
        ST_COPY
    } state_t;

    // CTRL sits at the top word of the address space
    function automatic int ctrl_offset(input int addr_w);
        return (1 << addr_w) - 1;
    endfunction

    function automatic logic [31:0] ball_to_word(input ball_t b);
        return {b.visible, 5'b0, b.radius, b.y, b.x};
    endfunction

endpackage

// File: rtl/ball_table_ctrl_if.sv
// Avalon-MM slave bus bundle for the ball table: readdata has a fixed latency of 1 after acceptance.
// The master holds a request steady while waitrequest is high.
interface ball_table_ctrl_if #(
    parameter int ADDR_W = 7
);
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [31:0]       avs_readdata;
    logic              avs_waitrequest;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, avs_waitrequest
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, avs_waitrequest
    );
endinterface

// File: rtl/ball_table_ctrl_vs_edge_sync.sv
// Two-flop synchronizer for the active-low vsync, followed by a registered falling-edge pulse.
// The pulse appears 3 clocks after the pin falls; there is no backpressure.
module vs_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic vs_async_i,
    output logic vs_fall_o
);
    // [0],[1] synchronizer stages, [2] previous synchronized value
    logic [2:0] sync_q;
    logic       fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b111;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], vs_async_i};
            fall_q <= sync_q[2] & ~sync_q[1];
        end
    end

    assign vs_fall_o = fall_q;
endmodule

// File: rtl/ball_table_ctrl.sv
// Double-buffered ball table: the bank swap happens on vsync, then the new active bank is copied back to the shadow bank; readdata and rd_data are registered with latency 1.
// Entry accesses stall during SWAP/COPY and CTRL never stalls; the frame-swap irq is built only with BALL_TABLE_IRQ_EN.
module ball_table_ctrl
    import ball_table_ctrl_pkg::*;
#(
    parameter  int NUM_BALLS = NUM_BALLS_DEFAULT,
    parameter  int ADDR_W    = 7,
    localparam int IDX_W     = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1
) (
    input  logic                Clk,
    input  logic                Reset_n,
    ball_table_ctrl_if.slave    avs,
    input  logic                VGA_VS,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [31:0]         rd_data,
    output logic                irq
);
    localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(ctrl_offset(ADDR_W));
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_BALLS - 1);

    state_t                          state_q, state_d;
    logic                            active_q;
    logic [15:0]                     frame_cnt_q;
    logic                            commit_lat_q;
    logic [IDX_W-1:0]                copy_idx_q;
    ball_t [1:0][NUM_BALLS-1:0]      bank_q;
    logic [31:0]                     readdata_q;
    logic [31:0]                     rd_data_q;

    logic        vs_fall;
    logic        busy, copying, pending, swap_go, waitreq;
    logic        hit_entry, hit_ctrl;
    logic        wr_acc, rd_acc, entry_wr, commit_wr, irq_clr;
    logic        irq_flag;
    logic        rd_in_range;
    logic [31:0] status;
    ball_t       wr_ball;
    logic [IDX_W-1:0] addr_idx;
    logic [ADDR_W:0]  addr_ext;
    logic [IDX_W:0]   rd_idx_ext;
    logic             unused_wdata;

    vs_edge_sync u_vs_sync (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .vs_async_i(VGA_VS),
        .vs_fall_o (vs_fall)
    );

    assign addr_ext    = {1'b0, avs.avs_address};
    assign hit_entry   = addr_ext < (ADDR_W + 1)'(NUM_BALLS);
    assign hit_ctrl    = avs.avs_address == CTRL_ADDR;
    assign addr_idx    = avs.avs_address[IDX_W-1:0];
    assign rd_idx_ext  = {1'b0, rd_idx};
    assign rd_in_range = rd_idx_ext < (IDX_W + 1)'(NUM_BALLS);

    assign wr_acc    = avs.avs_write & ~waitreq;
    assign rd_acc    = avs.avs_read & ~waitreq;
    assign entry_wr  = wr_acc & hit_entry;
    assign commit_wr = wr_acc & hit_ctrl & avs.avs_writedata[CTRL_COMMIT_BIT];
    assign irq_clr   = wr_acc & hit_ctrl & avs.avs_writedata[CTRL_IRQ_CLR_BIT];

    // Bits 30:26 are reserved in the entry format and are dropped on write
    assign wr_ball.visible = avs.avs_writedata[31];
    assign wr_ball.radius  = avs.avs_writedata[25:20];
    assign wr_ball.y       = avs.avs_writedata[19:10];
    assign wr_ball.x       = avs.avs_writedata[9:0];
    assign unused_wdata    = ^avs.avs_writedata[30:26];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (commit_wr) state_d = ST_PENDING;
            ST_PENDING: if (vs_fall)   state_d = ST_SWAP;
            ST_SWAP:    state_d = ST_COPY;
            ST_COPY: begin
                if (copy_idx_q == LAST_IDX) begin
                    state_d = (commit_lat_q | commit_wr) ? ST_PENDING : ST_IDLE;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q == ST_SWAP) || (state_q == ST_COPY);
        copying = (state_q == ST_COPY);
        pending = (state_q == ST_PENDING) || commit_lat_q;
        swap_go = (state_q == ST_PENDING) && vs_fall;
        waitreq = (avs.avs_read | avs.avs_write) & hit_entry & busy;
    end

    always_comb begin
        status = '0;
        status[STAT_PENDING_BIT]         = pending;
        status[STAT_COPYING_BIT]         = copying;
        status[STAT_IRQ_BIT]             = irq_flag;
        status[STAT_FRAME_LSB +: 16]     = frame_cnt_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            active_q     <= 1'b0;
            frame_cnt_q  <= 16'd0;
            commit_lat_q <= 1'b0;
            copy_idx_q   <= '0;
            bank_q       <= '0;
            readdata_q   <= 32'd0;
            rd_data_q    <= 32'd0;
        end else begin
            // The bank flips on entry to SWAP so a read in the SWAP cycle already sees the new frame
            if (swap_go) begin
                active_q    <= ~active_q;
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end

            // A commit accepted while busy is held until COPY finishes
            commit_lat_q <= (commit_lat_q | (commit_wr & busy)) & (state_d != ST_PENDING);

            if (state_q == ST_SWAP) begin
                copy_idx_q <= '0;
            end else if (state_q == ST_COPY) begin
                copy_idx_q <= copy_idx_q + IDX_W'(1);
            end

            if (state_q == ST_COPY) begin
                bank_q[~active_q][copy_idx_q] <= bank_q[active_q][copy_idx_q];
            end else if (entry_wr) begin
                bank_q[~active_q][addr_idx] <= wr_ball;
            end

            if (rd_acc) begin
                if (hit_entry) begin
                    readdata_q <= ball_to_word(bank_q[~active_q][addr_idx]);
                end else if (hit_ctrl) begin
                    readdata_q <= status;
                end else begin
                    readdata_q <= 32'd0;
                end
            end

            rd_data_q <= rd_in_range ? ball_to_word(bank_q[active_q][rd_idx]) : 32'd0;
        end
    end

`ifdef BALL_TABLE_IRQ_EN
    logic irq_q;

    // A set in the SWAP cycle takes priority over a clear in the same cycle
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            irq_q <= 1'b0;
        end else if (state_q == ST_SWAP) begin
            irq_q <= 1'b1;
        end else if (irq_clr) begin
            irq_q <= 1'b0;
        end
    end

    assign irq_flag = irq_q;
`else
    logic unused_irq_clr;

    assign unused_irq_clr = irq_clr;
    assign irq_flag       = 1'b0;
`endif

    assign avs.avs_readdata    = readdata_q;
    assign avs.avs_waitrequest = waitreq;
    assign rd_data             = rd_data_q;
    assign irq                 = irq_flag;
endmodule

// File: tb/tb_ball_table_ctrl.sv
// Directed bench for ball_table_ctrl covering commit/swap/copy timing, stalls, CTRL status, irq and reset.
// Builds with or without BALL_TABLE_IRQ_EN; irq expectations follow the macro.
module tb_ball_table_ctrl;

    localparam logic [6:0]  CTRL = 7'h7F;
    localparam logic [31:0] BALL = 32'h8050_A0C8;
`ifdef BALL_TABLE_IRQ_EN
    localparam logic [31:0] IRQB   = 32'h4;
    localparam logic        IRQ_ON = 1'b1;
`else
    localparam logic [31:0] IRQB   = 32'h0;
    localparam logic        IRQ_ON = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        VGA_VS;
    logic [3:0]  rd_idx;
    logic [31:0] rd_data;
    logic        irq;
    int          n_tests;
    int          n_fail;
    int          st;
    logic [31:0] d;

    ball_table_ctrl_if #(.ADDR_W(7)) avs_if ();

    ball_table_ctrl #(.NUM_BALLS(16), .ADDR_W(7)) dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .avs    (avs_if),
        .VGA_VS (VGA_VS),
        .rd_idx (rd_idx),
        .rd_data(rd_data),
        .irq    (irq)
    );

    always #10 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [6:0] a, input logic [31:0] wd, output int stall);
        @(negedge Clk);
        avs_if.avs_address   = a;
        avs_if.avs_writedata = wd;
        avs_if.avs_write     = 1'b1;
        #1;
        stall = 0;
        while (avs_if.avs_waitrequest !== 1'b0 && stall < 100) begin
            @(negedge Clk);
            #1;
            stall++;
        end
        if (stall >= 100) check("bus_write_timeout", 32'(stall), 32'd0);
        @(posedge Clk);
        #1;
        avs_if.avs_write = 1'b0;
    endtask

    task automatic bus_read(input logic [6:0] a, output logic [31:0] rd);
        int stall;
        @(negedge Clk);
        avs_if.avs_address = a;
        avs_if.avs_read    = 1'b1;
        #1;
        stall = 0;
        while (avs_if.avs_waitrequest !== 1'b0 && stall < 100) begin
            @(negedge Clk);
            #1;
            stall++;
        end
        if (stall >= 100) check("bus_read_timeout", 32'(stall), 32'd0);
        @(posedge Clk);
        #1;
        avs_if.avs_read = 1'b0;
        rd = avs_if.avs_readdata;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        Reset_n = 1'b0;
        VGA_VS  = 1'b1;
        rd_idx  = 4'd0;
        avs_if.avs_address   = 7'd0;
        avs_if.avs_read      = 1'b0;
        avs_if.avs_write     = 1'b0;
        avs_if.avs_writedata = 32'd0;

        // Reset state
        repeat (3) @(posedge Clk);
        #1;
        check("rst_readdata", avs_if.avs_readdata, 32'd0);
        check("rst_waitreq", {31'd0, avs_if.avs_waitrequest}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        bus_read(CTRL, d);
        check("ctrl_after_rst", d, 32'd0);
        repeat (2) @(posedge Clk);
        #1;
        check("rd0_after_rst", rd_data, 32'd0);

        // Shadow write, commit, swap timing
        bus_write(7'd3, BALL, st);
        bus_read(7'd3, d);
        check("shadow3", d, BALL);
        rd_idx = 4'd3;
        repeat (2) @(posedge Clk);
        #1;
        check("rd3_before_swap", rd_data, 32'd0);
        bus_write(CTRL, 32'h1, st);
        bus_read(CTRL, d);
        check("ctrl_pending", d, 32'h1);

        @(negedge Clk);
        VGA_VS = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("rd3_edge3", rd_data, 32'd0);
        @(posedge Clk);
        #1;
        check("rd3_edge4", rd_data, 32'd0);
        check("irq_in_swap", {31'd0, irq}, 32'd0);
        avs_if.avs_address = 7'd0;
        avs_if.avs_read    = 1'b1;
        #1;
        check("wait_in_swap", {31'd0, avs_if.avs_waitrequest}, 32'd1);
        avs_if.avs_read = 1'b0;
        @(posedge Clk);
        #1;
        check("rd3_after_swap", rd_data, BALL);
        check("irq_after_swap", {31'd0, irq}, {31'd0, IRQ_ON});
        VGA_VS = 1'b1;

        // Entry write during COPY stalls for the rest of the copy
        bus_write(7'd0, 32'h0000_1234, st);
        check("copy_stall_cycles", 32'(st), 32'd16);
        bus_read(7'd0, d);
        check("entry0_after_copy", d, 32'h0000_1234);
        bus_read(7'd3, d);
        check("entry3_copied", d, BALL);
        bus_read(CTRL, d);
        check("ctrl_frame1", d, 32'h0001_0000 | IRQB);
        bus_write(CTRL, 32'h2, st);
        check("irq_clr", {31'd0, irq}, 32'd0);
        bus_read(CTRL, d);
        check("ctrl_after_clr", d, 32'h0001_0000);
        rd_idx = 4'd0;
        repeat (2) @(posedge Clk);
        #1;
        check("rd0_active_untouched", rd_data, 32'd0);
        bus_write(7'd5, 32'hFFFF_FFFF, st);
        bus_read(7'd5, d);
        check("entry_reserved_mask", d, 32'h83FF_FFFF);

        // Out-of-range address
        bus_write(7'h40, 32'hFFFF_FFFF, st);
        bus_read(7'h40, d);
        check("oor_read", d, 32'd0);
        bus_read(7'd0, d);
        check("oor_entry0", d, 32'h0000_1234);
        bus_read(7'd3, d);
        check("oor_entry3", d, BALL);

        // vsync with nothing pending is ignored
        @(negedge Clk);
        VGA_VS = 1'b0;
        repeat (8) @(posedge Clk);
        VGA_VS = 1'b1;
        repeat (6) @(posedge Clk);
        bus_read(CTRL, d);
        check("idle_vs_ignored", d, 32'h0001_0000);

        // Commit coinciding with vs_fall in IDLE: pending only
        @(negedge Clk);
        VGA_VS = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        avs_if.avs_address   = CTRL;
        avs_if.avs_writedata = 32'h1;
        avs_if.avs_write     = 1'b1;
        @(posedge Clk);
        #1;
        avs_if.avs_write = 1'b0;
        VGA_VS = 1'b1;
        repeat (8) @(posedge Clk);
        bus_read(CTRL, d);
        check("coinc_no_swap", d, 32'h0001_0001);

        // Next vsync swaps; commit + irq clear land in the SWAP cycle
        @(negedge Clk);
        VGA_VS = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        avs_if.avs_address   = CTRL;
        avs_if.avs_writedata = 32'h3;
        avs_if.avs_write     = 1'b1;
        #1;
        check("ctrl_no_stall_swap", {31'd0, avs_if.avs_waitrequest}, 32'd0);
        @(posedge Clk);
        #1;
        avs_if.avs_write = 1'b0;
        VGA_VS = 1'b1;
        check("irq_set_wins", {31'd0, irq}, {31'd0, IRQ_ON});
        bus_read(CTRL, d);
        check("ctrl_copy_latched", d, 32'h0002_0003 | IRQB);
        repeat (20) @(posedge Clk);
        bus_read(CTRL, d);
        check("latched_pending", d, 32'h0002_0001 | IRQB);
        bus_write(CTRL, 32'h2, st);
        check("irq_cleared_again", {31'd0, irq}, 32'd0);

        @(negedge Clk);
        VGA_VS = 1'b0;
        repeat (5) @(posedge Clk);
        #1;
        VGA_VS = 1'b1;
        bus_read(CTRL, d);
        check("ctrl_copying", d, 32'h0003_0002 | IRQB);
        repeat (20) @(posedge Clk);
        bus_read(CTRL, d);
        check("ctrl_frame3", d, 32'h0003_0000 | IRQB);

        // Asynchronous reset in the middle of COPY
        bus_write(CTRL, 32'h1, st);
        rd_idx = 4'd3;
        @(negedge Clk);
        VGA_VS = 1'b0;
        repeat (8) @(posedge Clk);
        #1;
        check("rd3_pre_reset", rd_data, BALL);
        #3;
        Reset_n = 1'b0;
        #1;
        check("reset_rd_data", rd_data, 32'd0);
        check("reset_readdata", avs_if.avs_readdata, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        VGA_VS = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        bus_read(7'd3, d);
        check("reset_bank_cleared", d, 32'd0);
        bus_read(CTRL, d);
        check("reset_ctrl", d, 32'd0);
        check("reset_rd3", rd_data, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
